// File: rtl/hazard_controller.sv
// Pipeline hazard controller: stall/flush sequencing, EX forwarding selects,
// multi-cycle mul/div occupancy tracking and stall/flush performance counters.
module hazard_controller #(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic        MulDivStartE,
  input  logic        DmemReqM,
  input  logic        DmemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCycles
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned FWD_W  = 2;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PERF_W = 32;

  typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PERF_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic [PERF_W-1:0]   flush_cycles_q, flush_cycles_d;
  logic                mem_stall;
  logic                lw_stall;
  logic                md_stall;

  assign mem_stall = DmemReqM && !DmemReadyM;
  assign lw_stall  = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // MEM result takes precedence over WB since it is the younger write
  function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_W-1:0] rs);
    if (RegWriteM && (RdM != '0) && (RdM == rs)) begin
      return 2'b10;
    end else if (RegWriteW && (RdW != '0) && (RdW == rs)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    ForwardAE = '0;
    ForwardBE = '0;
    if (!rst) begin
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
    end
  end

  // Mul/div FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a memory wait freezes the FSM along with the rest of the pipe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (MulDivStartE && !mem_stall) begin
          cnt_d   = CNT_W'(MD_LATENCY - 2);
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (!mem_stall) begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          else             state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Stall/flush outputs in priority order
  always_comb begin
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushM   = 1'b0;
    FlushW   = 1'b0;
    md_stall = (state_q == RUN) ? MulDivStartE : (cnt_q != '0);
    if (!rst) begin
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (md_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q + PERF_W'(StallF);
    flush_cycles_d = flush_cycles_q + PERF_W'(FlushD | FlushE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushCycles = flush_cycles_q;

endmodule
